// File: rtl/attendant_call_station.sv
// Attendant-side call-light responder: queues seat calls in arrival order and serves them one at a time.
// Define ESCALATE_EN to build the wait counter and the escalate flag.
module attendant_call_station #(
    parameter int NUM_SEATS       = 8,
    parameter int SEAT_W          = $clog2(NUM_SEATS),
    parameter int ESCALATE_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SEATS-1:0] seat_light,
    input  logic                 ack_button,
    output logic                 serve_valid,
    output logic [SEAT_W-1:0]    serve_seat,
    output logic [NUM_SEATS-1:0] seat_cancel,
    output logic [SEAT_W:0]      pending_count,
    output logic                 escalate
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_CANCEL  = 2'd2;
    localparam logic [1:0] S_CHECK   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [NUM_SEATS-1:0] light_prev_q;
    logic [NUM_SEATS-1:0] req_q, req_d;
    logic [NUM_SEATS-1:0] queued_q, queued_d;
    logic [SEAT_W-1:0]    serve_seat_q, serve_seat_d;

    logic [SEAT_W-1:0]    fifo_q [NUM_SEATS];
    logic [SEAT_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [SEAT_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [SEAT_W:0]      fill_q, fill_d;

    logic                 enq_valid;
    logic [SEAT_W-1:0]    enq_idx;
    logic [NUM_SEATS-1:0] enq_onehot;
    logic                 pop;
    logic [SEAT_W-1:0]    head;
    logic [NUM_SEATS-1:0] rise_new;
    logic [NUM_SEATS-1:0] clr_mask;
    logic [NUM_SEATS-1:0] set_mask;

    function automatic logic [SEAT_W-1:0] ptr_inc(input logic [SEAT_W-1:0] p);
        if (p == SEAT_W'(NUM_SEATS - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Lowest-index pending request wins the single enqueue slot.
    always_comb begin
        enq_valid = |req_q;
        enq_idx   = '0;
        for (int i = NUM_SEATS - 1; i >= 0; i--) begin
            if (req_q[i]) begin
                enq_idx = SEAT_W'(i);
            end
        end
        enq_onehot = enq_valid ? (NUM_SEATS'(1) << enq_idx) : '0;
    end

    assign head     = fifo_q[rd_ptr_q];
    assign rise_new = seat_light & ~light_prev_q & ~queued_q;

    always_comb begin
        state_d      = state_q;
        serve_seat_d = serve_seat_q;
        pop          = 1'b0;
        clr_mask     = '0;
        set_mask     = '0;
        case (state_q)
            S_IDLE: begin
                if (fill_q != '0) begin
                    pop = 1'b1;
                    if (seat_light[head]) begin
                        state_d      = S_PRESENT;
                        serve_seat_d = head;
                    end else begin
                        clr_mask[head] = 1'b1;
                    end
                end
            end
            S_PRESENT: begin
                if (ack_button) begin
                    state_d = S_CANCEL;
                end else if (!seat_light[serve_seat_q]) begin
                    clr_mask[serve_seat_q] = 1'b1;
                    state_d                = S_IDLE;
                end
            end
            S_CANCEL: begin
                state_d = S_CHECK;
            end
            default: begin
                // A light still on after the pulse is a fresh call.
                clr_mask[serve_seat_q] = 1'b1;
                set_mask[serve_seat_q] = seat_light[serve_seat_q];
                state_d                = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_d    = (req_q & ~enq_onehot) | rise_new | set_mask;
        queued_d = (queued_q & ~clr_mask) | rise_new | set_mask;
        wr_ptr_d = enq_valid ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({enq_valid, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            light_prev_q <= '0;
            req_q        <= '0;
            queued_q     <= '0;
            serve_seat_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
        end else begin
            state_q      <= state_d;
            light_prev_q <= seat_light;
            req_q        <= req_d;
            queued_q     <= queued_d;
            serve_seat_q <= serve_seat_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_valid) begin
            fifo_q[wr_ptr_q] <= enq_idx;
        end
    end

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            pending_count = pending_count + (SEAT_W + 1)'(queued_q[i]);
        end
    end

    assign serve_valid = (state_q == S_PRESENT);
    assign serve_seat  = serve_seat_q;
    assign seat_cancel = (state_q == S_CANCEL) ? (NUM_SEATS'(1) << serve_seat_q) : '0;

`ifdef ESCALATE_EN
    localparam int WAIT_W = $clog2(ESCALATE_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;

    // Counts presented cycles including the current one, so it reads n in the nth cycle.
    always_comb begin
        wait_d = '0;
        if (state_d == S_PRESENT) begin
            wait_d = (wait_q == WAIT_W'(ESCALATE_CYCLES)) ? wait_q : wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign escalate = (state_q == S_PRESENT) && (wait_q == WAIT_W'(ESCALATE_CYCLES));
`else
    logic unused_esc_cfg;
    assign unused_esc_cfg = (ESCALATE_CYCLES != 0);
    assign escalate       = 1'b0;
`endif

endmodule

// File: tb/tb_attendant_call_station.sv
// Directed bench for attendant_call_station: hand-computed vectors, cycle by cycle.
module tb_attendant_call_station;

    localparam int NS  = 8;
    localparam int SW  = 3;
    localparam int ESC = 10;
`ifdef ESCALATE_EN
    localparam int ESC_EXP = 1;
`else
    localparam int ESC_EXP = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic [NS-1:0] seat_light;
    logic          ack_button;
    logic          serve_valid;
    logic [SW-1:0] serve_seat;
    logic [NS-1:0] seat_cancel;
    logic [SW:0]   pending_count;
    logic          escalate;

    int n_vec;
    int n_err;

    attendant_call_station #(
        .NUM_SEATS       (NS),
        .ESCALATE_CYCLES (ESC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seat_light    (seat_light),
        .ack_button    (ack_button),
        .serve_valid   (serve_valid),
        .serve_seat    (serve_seat),
        .seat_cancel   (seat_cancel),
        .pending_count (pending_count),
        .escalate      (escalate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int v, input int s, input int c, input int p);
        check({tag, ".valid"}, 32'(serve_valid), 32'(v));
        if (v == 1) begin
            check({tag, ".seat"}, 32'(serve_seat), 32'(s));
        end
        check({tag, ".cancel"}, 32'(seat_cancel), 32'(c));
        if (p >= 0) begin
            check({tag, ".pend"}, 32'(pending_count), 32'(p));
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        seat_light = '0;
        ack_button = 1'b0;
        tick();
        tick();
        chk_out("rst", 0, 0, 0, 0);
        check("rst.seat", 32'(serve_seat), 0);
        check("rst.esc", 32'(escalate), 0);

        // Seat 2 lit across reset release
        seat_light = 8'h04;
        rst_n      = 1'b1;
        tick();
        chk_out("t1.e0", 0, 0, 0, 1);
        tick();
        chk_out("t1.e1", 0, 0, 0, 1);
        tick();
        chk_out("t1.e2", 1, 2, 0, 1);
        ack_button = 1'b1;
        tick();
        chk_out("t1.cancel", 0, 0, 8'h04, 1);
        ack_button = 1'b0;
        seat_light = '0;
        tick();
        chk_out("t1.check", 0, 0, 0, 1);
        tick();
        chk_out("t1.idle", 0, 0, 0, 0);

        // Seats 5 and 1 together
        seat_light = 8'h22;
        tick();
        chk_out("t2.rise", 0, 0, 0, 2);
        tick();
        chk_out("t2.enq", 0, 0, 0, 2);
        tick();
        chk_out("t2.pres1", 1, 1, 0, 2);
        ack_button = 1'b1;
        tick();
        chk_out("t2.cancel1", 0, 0, 8'h02, 2);
        ack_button = 1'b0;
        seat_light = 8'h20;
        tick();
        chk_out("t2.check1", 0, 0, 0, 2);
        tick();
        chk_out("t2.idle", 0, 0, 0, 1);
        tick();
        chk_out("t2.pres5", 1, 5, 0, 1);
        seat_light = '0;
        tick();
        chk_out("t2.selfcan", 0, 0, 0, 0);

        // Seat 3 queued behind seat 0, then drops
        seat_light = 8'h01;
        tick();
        seat_light = 8'h09;
        tick();
        chk_out("t3.q2", 0, 0, 0, 2);
        tick();
        chk_out("t3.pres0", 1, 0, 0, 2);
        seat_light = 8'h01;
        tick();
        chk_out("t3.hold0", 1, 0, 0, 2);
        ack_button = 1'b1;
        tick();
        chk_out("t3.cancel0", 0, 0, 8'h01, 2);
        ack_button = 1'b0;
        seat_light = '0;
        tick();
        chk_out("t3.check0", 0, 0, 0, 2);
        tick();
        chk_out("t3.idle", 0, 0, 0, 1);
        tick();
        chk_out("t3.skip3", 0, 0, 0, 0);
        tick();
        chk_out("t3.quiet", 0, 0, 0, 0);

        // Seat 6 re-pressed through the cancel pulse
        seat_light = 8'h40;
        tick();
        tick();
        tick();
        chk_out("t4.pres", 1, 6, 0, 1);
        ack_button = 1'b1;
        tick();
        chk_out("t4.cancel", 0, 0, 8'h40, 1);
        ack_button = 1'b0;
        tick();
        chk_out("t4.check", 0, 0, 0, 1);
        tick();
        chk_out("t4.requeue", 0, 0, 0, 1);
        tick();
        chk_out("t4.enq", 0, 0, 0, 1);
        tick();
        chk_out("t4.pres2", 1, 6, 0, 1);
        ack_button = 1'b1;
        tick();
        chk_out("t4.cancel2", 0, 0, 8'h40, 1);
        seat_light = '0;
        tick();
        chk_out("t4.check2", 0, 0, 0, 1);
        tick();
        chk_out("t4.idle", 0, 0, 0, 0);
        ack_button = 1'b0;

        // Unanswered call on seat 4
        seat_light = 8'h10;
        tick();
        tick();
        tick();
        chk_out("t5.pres", 1, 4, 0, 1);
        check("t5.esc1", 32'(escalate), 0);
        for (int i = 2; i < ESC; i++) begin
            tick();
            check("t5.esc_early", 32'(escalate), 0);
        end
        tick();
        check("t5.esc_on", 32'(escalate), 32'(ESC_EXP));
        check("t5.valid", 32'(serve_valid), 1);
        tick();
        check("t5.esc_held", 32'(escalate), 32'(ESC_EXP));
        ack_button = 1'b1;
        tick();
        check("t5.esc_cancel", 32'(escalate), 0);
        chk_out("t5.cancel", 0, 0, 8'h10, 1);
        ack_button = 1'b0;
        seat_light = '0;
        tick();
        tick();
        chk_out("t5.idle", 0, 0, 0, 0);

        // Reset while the cancel pulse is out
        seat_light = 8'h80;
        tick();
        tick();
        tick();
        chk_out("t6.pres", 1, 7, 0, 1);
        ack_button = 1'b1;
        tick();
        chk_out("t6.cancel", 0, 0, 8'h80, 1);
        rst_n      = 1'b0;
        ack_button = 1'b0;
        tick();
        chk_out("t6.rst", 0, 0, 0, 0);
        check("t6.rst.seat", 32'(serve_seat), 0);
        check("t6.rst.esc", 32'(escalate), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("t6.e0", 0, 0, 0, 1);
        tick();
        chk_out("t6.e1", 0, 0, 0, 1);
        tick();
        chk_out("t6.e2", 1, 7, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
